// File: rtl/conv2d_stream_kxk.sv
// Streaming KxK 2-D convolution. The window is built from KSIZE-1 line
// buffers plus a KxK register window. Coefficients are unsigned and
// programmable at runtime. Three register stages follow the window:
// products, adder tree, then round/shift/saturate. A single advance
// signal stalls the whole pipeline under output backpressure.
module conv2d_stream_kxk #(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int KSIZE      = 5,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int SHIFT      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [5:0]            cfg_addr,
    input  logic [COEF_WIDTH-1:0] cfg_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_eof
);

    localparam int KK     = KSIZE * KSIZE;
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(KK);
    localparam int CW     = $clog2(IMG_WIDTH);
    localparam int RW     = $clog2(IMG_HEIGHT);
    localparam int CENTRE = (KK - 1) / 2;

    // Identity gain 2^SHIFT, clipped when it does not fit in a coefficient.
    localparam logic [COEF_WIDTH-1:0] CENTRE_COEF =
        (SHIFT >= COEF_WIDTH) ? {COEF_WIDTH{1'b1}} : COEF_WIDTH'(1 << SHIFT);
    localparam logic [ACC_W:0] RND     = (ACC_W + 1)'(1) << (SHIFT - 1);
    localparam logic [ACC_W:0] SAT_MAX = (ACC_W + 1)'((1 << DATA_WIDTH) - 1);

    logic                  adv;
    logic                  accept;
    logic                  win_ok;
    logic                  col_end;
    logic                  row_end;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;

    logic [DATA_WIDTH-1:0] lb     [KSIZE-1][IMG_WIDTH];
    logic [DATA_WIDTH-1:0] colvec [KSIZE];
    logic [DATA_WIDTH-1:0] win    [KSIZE][KSIZE];
    logic [DATA_WIDTH-1:0] win_n  [KSIZE][KSIZE];
    logic [COEF_WIDTH-1:0] coef   [KK];
    logic [PROD_W-1:0]     prod_c [KK];
    logic [PROD_W-1:0]     prod_q [KK];
    logic [ACC_W-1:0]      sum_c;
    logic [ACC_W-1:0]      sum_q;
    logic [ACC_W:0]        rnd;
    logic [ACC_W:0]        scaled;
    logic [DATA_WIDTH-1:0] sat_c;

    logic                  v1, v2;
    logic                  last1, eof1, last2, eof2;

    assign adv     = !m_valid || m_ready;
    assign s_ready = adv;
    assign accept  = s_valid && adv;
    assign col_end = (col == CW'(IMG_WIDTH - 1));
    assign row_end = (row == RW'(IMG_HEIGHT - 1));
    assign win_ok  = (row >= RW'(KSIZE - 1)) && (col >= CW'(KSIZE - 1));

    // New window column: oldest line at index 0, incoming pixel at the bottom.
    always_comb begin
        for (int r = 0; r < KSIZE; r++) colvec[r] = '0;
        colvec[KSIZE-1] = s_data;
        for (int i = 0; i < KSIZE - 1; i++) colvec[KSIZE-2-i] = lb[i][col];
    end

    // Window as it will look after this pixel shifts in (leftmost = oldest column).
    always_comb begin
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE - 1; c++) win_n[r][c] = win[r][c+1];
            win_n[r][KSIZE-1] = colvec[r];
        end
    end

    // Products use the post-shift window so S1 captures in the acceptance cycle.
    always_comb begin
        for (int r = 0; r < KSIZE; r++)
            for (int c = 0; c < KSIZE; c++)
                prod_c[r*KSIZE+c] = PROD_W'(win_n[r][c]) * PROD_W'(coef[r*KSIZE+c]);
    end

    // Adder tree over the registered products.
    always_comb begin
        sum_c = '0;
        for (int i = 0; i < KK; i++) sum_c = sum_c + ACC_W'(prod_q[i]);
    end

    // Round to nearest, normalise, clip to the pixel range.
    always_comb begin
        rnd    = {1'b0, sum_q} + RND;
        scaled = rnd >> SHIFT;
        sat_c  = (scaled > SAT_MAX) ? {DATA_WIDTH{1'b1}} : scaled[DATA_WIDTH-1:0];
    end

    // Line buffers and window register; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][col] <= s_data;
            for (int i = 1; i < KSIZE - 1; i++) lb[i][col] <= lb[i-1][col];
            win <= win_n;
        end
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Coefficient file; writes land even while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KK; i++) coef[i] <= (i == CENTRE) ? CENTRE_COEF : '0;
        end else if (cfg_we) begin
            for (int i = 0; i < KK; i++)
                if (cfg_addr == 6'(i)) coef[i] <= cfg_data;
        end
    end

    // Datapath registers for S1 and S2.
    always_ff @(posedge clk) begin
        if (adv) begin
            prod_q <= prod_c;
            sum_q  <= sum_c;
        end
    end

    // Valid and flag pipeline plus the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            last1   <= 1'b0;
            eof1    <= 1'b0;
            last2   <= 1'b0;
            eof2    <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_eof   <= 1'b0;
        end else if (adv) begin
            v1      <= accept && win_ok;
            last1   <= col_end;
            eof1    <= col_end && row_end;
            v2      <= v1;
            last2   <= last1;
            eof2    <= eof1;
            m_valid <= v2;
            m_data  <= sat_c;
            m_last  <= last2;
            m_eof   <= eof2;
        end
    end

endmodule

// File: tb/tb_conv2d_stream_kxk.sv
// Directed bench for conv2d_stream_kxk with a 3x3 kernel on an 8x6 frame.
module tb_conv2d_stream_kxk;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [5:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_eof;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int eof_cnt = 0;
    int acc_count = 0;
    int eof_base;
    int st_t;
    int d0, l0, e0;

    int od_q[$];
    int ol_q[$];
    int oe_q[$];
    int oc_q[$];
    int acc_q[$];

    conv2d_stream_kxk #(
        .DATA_WIDTH(8), .COEF_WIDTH(8), .KSIZE(3),
        .IMG_WIDTH(8), .IMG_HEIGHT(6), .SHIFT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .m_eof(m_eof)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records each transfer that will happen on the next edge.
    always @(negedge clk) begin
        #2;
        if (!rst && m_valid && m_ready) begin
            od_q.push_back(int'(m_data));
            ol_q.push_back(int'(m_last));
            oe_q.push_back(int'(m_eof));
            oc_q.push_back(cyc);
            if (m_eof) eof_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send_pixel(input logic [7:0] d);
        int t;
        s_valid = 1'b1;
        s_data  = d;
        t = 0;
        @(negedge clk); #1;
        while (!s_ready && t < 1000) begin
            @(negedge clk); #1;
            t++;
        end
        if (t >= 1000) check("sready_timeout", 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        acc_q.push_back(cyc);
        acc_count++;
    endtask

    task automatic send_frame(input int mode, input int val, input int n);
        for (int i = 0; i < n; i++)
            send_pixel(mode == 0 ? 8'(i % 48) : 8'(val));
    endtask

    task automatic set_coef(input int a, input int v);
        cfg_we   = 1'b1;
        cfg_addr = 6'(a);
        cfg_data = 8'(v);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < 9; i++) set_coef(i, v);
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        od_q.delete(); ol_q.delete(); oe_q.delete(); oc_q.delete(); acc_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // mode 0: identity on ramp (centre pixel); 1: constant val; 2: top-left pixel of ramp.
    task automatic check_frame(input string tag, input int mode, input int val, input int base);
        int e;
        for (int k = 0; k < 24; k++) begin
            if (base + k < od_q.size()) begin
                if (mode == 0)      e = ((k / 6) + 1) * 8 + (k % 6) + 1;
                else if (mode == 1) e = val;
                else                e = (k / 6) * 8 + (k % 6);
                check({tag, "_data"}, od_q[base+k], e);
                check({tag, "_last"}, ol_q[base+k], int'(k % 6 == 5));
                check({tag, "_eof"},  oe_q[base+k], int'(k == 23));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_data",  int'(m_data), 0);
        check("rst_m_last",  int'(m_last), 0);
        check("rst_m_eof",   int'(m_eof), 0);
        check("rst_s_ready", int'(s_ready), 1);

        // Identity coefficients on a ramp frame.
        clear_q();
        send_frame(0, 0, 48);
        drain();
        check("s1_count", od_q.size(), 24);
        check_frame("s1", 0, 0, 0);
        if (od_q.size() == 24 && acc_q.size() == 48) begin
            check("s1_latency_first", oc_q[0] - acc_q[18], 2);
            check("s1_latency_last",  oc_q[23] - acc_q[47], 2);
            check("s1_throughput",    acc_q[47] - acc_q[0], 47);
        end

        // Uniform 28 on constant 255; out-of-range writes must be ignored.
        clear_q();
        set_all(28);
        set_coef(9, 255);
        set_coef(63, 255);
        send_frame(1, 255, 48);
        drain();
        check("s2_count", od_q.size(), 24);
        check_frame("s2", 1, 251, 0);

        // Saturation.
        clear_q();
        set_all(255);
        send_frame(1, 255, 48);
        drain();
        check("s3sat_count", od_q.size(), 24);
        check_frame("s3sat", 1, 255, 0);

        // Rounding around the half point.
        clear_q();
        set_all(0);
        set_coef(4, 1);
        send_frame(1, 128, 48);
        drain();
        check("s3r128_count", od_q.size(), 24);
        check_frame("s3r128", 1, 1, 0);
        clear_q();
        send_frame(1, 127, 48);
        drain();
        check("s3r127_count", od_q.size(), 24);
        check_frame("s3r127", 1, 0, 0);

        // Backpressure: 10 stalled cycles mid-frame.
        do_reset();
        clear_q();
        fork
            send_frame(0, 0, 48);
            begin
                st_t = 0;
                while (od_q.size() < 3 && st_t < 2000) begin
                    @(negedge clk);
                    st_t++;
                end
                @(negedge clk);
                st_t = 0;
                while (!m_valid && st_t < 100) begin
                    @(negedge clk);
                    st_t++;
                end
                check("s4_stall_start", int'(m_valid), 1);
                m_ready = 1'b0;
                #1;
                d0 = int'(m_data); l0 = int'(m_last); e0 = int'(m_eof);
                check("s4_sready_first", int'(s_ready), 0);
                repeat (9) begin
                    @(negedge clk); #1;
                    check("s4_sready", int'(s_ready), 0);
                    check("s4_mvalid", int'(m_valid), 1);
                    check("s4_data_hold", int'(m_data), d0);
                    check("s4_last_hold", int'(m_last), l0);
                    check("s4_eof_hold",  int'(m_eof), e0);
                end
                @(negedge clk);
                m_ready = 1'b1;
            end
        join
        drain();
        check("s4_count", od_q.size(), 24);
        check_frame("s4", 0, 0, 0);

        // Reset mid-frame, with a coefficient write colliding with reset.
        set_all(28);
        clear_q();
        send_frame(0, 0, 20);
        rst      = 1'b1;
        cfg_we   = 1'b1;
        cfg_addr = 6'd0;
        cfg_data = 8'd255;
        @(posedge clk); #1;
        rst    = 1'b0;
        cfg_we = 1'b0;
        check("s5_m_valid", int'(m_valid), 0);
        check("s5_m_data",  int'(m_data), 0);
        check("s5_s_ready", int'(s_ready), 1);
        clear_q();
        send_frame(0, 0, 48);
        drain();
        check("s5_count", od_q.size(), 24);
        check_frame("s5", 0, 0, 0);

        // Two back-to-back frames; new set (top-left only) written between them.
        clear_q();
        eof_base  = eof_cnt;
        acc_count = 0;
        fork
            send_frame(0, 0, 96);
            begin
                st_t = 0;
                while (acc_count < 49 && st_t < 2000) begin
                    @(posedge clk); #1;
                    st_t++;
                end
                set_coef(4, 0);
                set_coef(0, 255);
            end
        join
        drain();
        check("s6_count", od_q.size(), 48);
        check("s6_gapless", (acc_q.size() == 96) ? acc_q[95] - acc_q[0] : -1, 95);
        check_frame("s6f1", 0, 0, 0);
        check_frame("s6f2", 2, 0, 24);
        check("s6_eof_count", eof_cnt - eof_base, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
